// File: rtl/gated_pulse_counter.sv
// Multi-channel gated pulse counter: counts synchronised VMOD rising edges over a
// 2^(TW-MODE) cycle window and latches per-channel counts/saturation flags at each boundary.
module gated_pulse_counter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TW          = 16,
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [1:0]            MODE,
  input  logic [CH-1:0]         VMOD,
  output logic [CH*WIDTH-1:0]   Q,
  output logic [CH-1:0]         OVF,
  output logic                  VALID,
  output logic [TW-1:0]         timer
);

  localparam int unsigned LAST_SYNC = SYNC_STAGES - 1;

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    dly_q;
  logic [CH-1:0]    edge_c;
  logic [CH-1:0]    full_c;
  logic [WIDTH-1:0] count_q [CH];
  logic [CH-1:0]    sat_q;
  logic [1:0]       mode_l;
  logic [TW-1:0]    last_c;
  logic             term_c;

  // Synchroniser chain plus edge-detect delay flop; runs regardless of EN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= VMOD;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      dly_q <= sync_q[LAST_SYNC];
    end
  end

  assign edge_c = sync_q[LAST_SYNC] & ~dly_q;
  assign last_c = {TW{1'b1}} >> mode_l;
  assign term_c = (timer == last_c);

  always_comb begin
    full_c = '0;
    for (int i = 0; i < int'(CH); i++) full_c[i] = &count_q[i];
  end

  // Window timer, per-channel counters and the latched result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timer  <= '0;
      mode_l <= '0;
      VALID  <= 1'b0;
      Q      <= '0;
      OVF    <= '0;
      sat_q  <= '0;
      for (int i = 0; i < int'(CH); i++) count_q[i] <= '0;
    end else if (!EN) begin
      timer  <= '0;
      mode_l <= MODE;
      VALID  <= 1'b0;
      sat_q  <= '0;
      for (int i = 0; i < int'(CH); i++) count_q[i] <= '0;
    end else if (term_c) begin
      // Terminal-cycle edges are credited to the closing window.
      timer  <= '0;
      mode_l <= MODE;
      VALID  <= 1'b1;
      sat_q  <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        count_q[i] <= '0;
        Q[i*WIDTH +: WIDTH] <= full_c[i] ? count_q[i] : count_q[i] + WIDTH'(edge_c[i]);
        OVF[i] <= sat_q[i] | (full_c[i] & edge_c[i]);
      end
    end else begin
      timer <= timer + TW'(1);
      VALID <= 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
        if (edge_c[i] && !full_c[i]) count_q[i] <= count_q[i] + WIDTH'(1);
        if (edge_c[i] && full_c[i])  sat_q[i]   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Randomised scoreboard bench for gated_pulse_counter with an edge-counting reference model.
module tb_gated_pulse_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned TW    = 6;
  localparam int unsigned CH    = 2;
  localparam int unsigned SS    = 2;
  localparam int          CMAX  = (1 << WIDTH) - 1;

  logic                CLK   = 1'b0;
  logic                RST_N = 1'b0;
  logic                EN    = 1'b0;
  logic [1:0]          MODE  = 2'd0;
  logic [CH-1:0]       VMOD  = '0;
  logic [CH*WIDTH-1:0] Q;
  logic [CH-1:0]       OVF;
  logic                VALID;
  logic [TW-1:0]       timer;

  gated_pulse_counter #(.WIDTH(WIDTH), .TW(TW), .CH(CH), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .VMOD(VMOD),
    .Q(Q), .OVF(OVF), .VALID(VALID), .timer(timer)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [CH*WIDTH-1:0] q;
    logic [CH-1:0]       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: history of sampled VMOD, raw edge totals, window position.
  logic [CH-1:0] vh [SS+2];
  logic [CH-1:0] m_rise;
  int            total [CH];
  int            m_cyc;
  int            m_len;
  bit            m_valid;
  exp_t          m_e;
  int            valids_seen = 0;

  function automatic int win_len(input logic [1:0] m);
    return 1 << (int'(TW) - int'(m));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // An edge sampled on VMOD at clock n is counted by the clock n+SS that closes its cycle.
  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < int'(SS) + 2; k++) vh[k] = '0;
      for (int i = 0; i < int'(CH); i++) total[i] = 0;
      m_cyc   = 0;
      m_len   = win_len(2'd0);
      m_valid = 1'b0;
      sb.delete();
    end else begin
      for (int k = int'(SS) + 1; k > 0; k--) vh[k] = vh[k-1];
      vh[0]   = VMOD;
      m_rise  = vh[SS] & ~vh[SS+1];
      m_valid = 1'b0;
      if (EN) begin
        for (int i = 0; i < int'(CH); i++) total[i] += int'(m_rise[i]);
        if (m_cyc == m_len - 1) begin
          for (int i = 0; i < int'(CH); i++) begin
            m_e.q[i*WIDTH +: WIDTH] = WIDTH'((total[i] > CMAX) ? CMAX : total[i]);
            m_e.ovf[i]              = (total[i] > CMAX);
            total[i]                = 0;
          end
          sb.push_back(m_e);
          m_cyc   = 0;
          m_len   = win_len(MODE);
          m_valid = 1'b1;
        end else begin
          m_cyc++;
        end
      end else begin
        for (int i = 0; i < int'(CH); i++) total[i] = 0;
        m_cyc = 0;
        m_len = win_len(MODE);
      end
    end
  end

  // Monitor: window position every cycle, scoreboard pop on each VALID, held outputs in between.
  logic [CH*WIDTH-1:0] held_q;
  logic [CH-1:0]       held_ovf;
  exp_t                got_e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      held_q   = '0;
      held_ovf = '0;
    end else begin
      chk("timer", 64'(timer), 64'(m_cyc));
      chk("valid", 64'(VALID), 64'(m_valid));
      if (VALID) begin
        valids_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: VALID with no expected window at %0t", $time);
        end else begin
          got_e    = sb.pop_front();
          held_q   = got_e.q;
          held_ovf = got_e.ovf;
        end
      end
      chk("q", 64'(Q), 64'(held_q));
      chk("ovf", 64'(OVF), 64'(held_ovf));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"},     64'(Q),     64'd0);
    chk({tag, "_ovf"},   64'(OVF),   64'd0);
    chk({tag, "_valid"}, 64'(VALID), 64'd0);
    chk({tag, "_timer"}, 64'(timer), 64'd0);
  endtask

  task automatic random_phase(input int cycles);
    int en_off = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge CLK);
      if ($urandom_range(0, 2) == 0) VMOD = CH'($urandom);
      if (en_off > 0) begin
        en_off--;
        EN = (en_off == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        en_off = int'($urandom_range(1, 8));
        EN = 1'b0;
      end
      if ($urandom_range(0, 59) == 0) MODE = 2'($urandom_range(0, 3));
    end
    @(negedge CLK);
    EN = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst0");
    RST_N = 1'b1;
    EN    = 1'b1;
    MODE  = 2'd0;

    // Idle windows of 64 cycles with no edges.
    repeat (140) @(negedge CLK);

    // Short windows with a 1-high/3-low pulse train on ch0.
    MODE = 2'd3;
    for (int n = 0; n < 120; n++) begin
      @(negedge CLK);
      VMOD = CH'((n % 4) == 0);
    end

    // Saturate ch0 with a toggle every cycle, then a quiet window.
    MODE = 2'd0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      VMOD = CH'(n % 2);
    end
    VMOD = '0;
    repeat (140) @(negedge CLK);

    random_phase(3000);

    // Asynchronous reset in the middle of a cycle.
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst1");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    random_phase(600);

    @(negedge CLK);
    EN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    checks++;
    if (valids_seen < 20) begin
      errors++;
      $display("FAIL valid_count: got %0d expected at least 20", valids_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
